// File: rtl/risky_run_ctrl_if.sv
// Dump stream interface for risky_run_ctrl. The controller drives register
// file beats, and the harness or FPGA wrapper accepts them with dump_ready.
interface risky_run_ctrl_if #(
  parameter int XLEN = 32,
  parameter int IDXW = 5
);
  logic            dump_valid;
  logic            dump_ready;
  logic [IDXW-1:0] dump_idx;
  logic [XLEN-1:0] dump_data;

  modport master (
    output dump_valid,
    output dump_idx,
    output dump_data,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_idx,
    input  dump_data,
    output dump_ready
  );
endinterface

// File: rtl/risky_run_ctrl.sv
// Run controller for the risky core. It holds the core in reset for a fixed
// number of cycles, runs it while counting cycles, halts on tohost store,
// ECALL or cycle limit, and then streams the frozen register file out.
module risky_run_ctrl #(
  parameter int                  XLEN         = 32,
  parameter int                  NUM_REGS     = 32,
  parameter int                  RESET_CYCLES = 2,
  parameter int                  MAX_CYCLES   = 100,
  parameter logic [XLEN-1:0]     TOHOST_ADDR  = 32'h0000_1000,
  parameter bit                  DUMP_EN      = 1'b1,
  localparam int                 IW           = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int                 CW           = $clog2(MAX_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              core_rst_n,
  output logic              core_en,
  input  logic              retire_valid,
  input  logic              retire_is_ecall,
  input  logic              mem_we,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic [IW-1:0]     rf_raddr,
  input  logic [XLEN-1:0]   rf_rdata,
  risky_run_ctrl_if.master  dump,
  output logic              done,
  output logic [1:0]        status,
  output logic [CW-1:0]     cycle_count,
  output logic [XLEN-1:0]   tohost_value
);

  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HOLD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_DUMP = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] ST_NONE    = 2'd0;
  localparam logic [1:0] ST_ECALL   = 2'd1;
  localparam logic [1:0] ST_TOHOST  = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  // Hold counter counts down to zero, so the load value is one less than
  // the number of hold cycles.
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] LAST_CYCLE = CW'(MAX_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_REGS - 1);

  logic [2:0]      state_r;
  logic [HW-1:0]   hold_cnt_r;
  logic            core_rst_n_r;
  logic            core_en_r;
  logic            dump_valid_r;
  logic [IW-1:0]   dump_idx_r;
  logic            done_r;
  logic [1:0]      status_r;
  logic [CW-1:0]   cycle_count_r;
  logic [XLEN-1:0] tohost_value_r;

  logic            tohost_hit_s;
  logic            ecall_hit_s;
  logic            halt_s;
  logic [1:0]      halt_status_s;

  assign core_rst_n      = core_rst_n_r;
  assign core_en         = core_en_r;
  assign rf_raddr        = dump_idx_r;
  assign dump.dump_valid = dump_valid_r;
  assign dump.dump_idx   = dump_idx_r;
  assign dump.dump_data  = rf_rdata;
  assign done            = done_r;
  assign status          = status_r;
  assign cycle_count     = cycle_count_r;
  assign tohost_value    = tohost_value_r;

  // Halt event decode with tohost > ecall > timeout priority.
  always_comb begin
    tohost_hit_s  = mem_we && (mem_addr == TOHOST_ADDR) && (mem_wdata != {XLEN{1'b0}});
    ecall_hit_s   = retire_valid && retire_is_ecall;
    halt_s        = 1'b0;
    halt_status_s = ST_NONE;
    if (tohost_hit_s) begin
      halt_s        = 1'b1;
      halt_status_s = ST_TOHOST;
    end else if (ecall_hit_s) begin
      halt_s        = 1'b1;
      halt_status_s = ST_ECALL;
    end else if (cycle_count_r == LAST_CYCLE) begin
      halt_s        = 1'b1;
      halt_status_s = ST_TIMEOUT;
    end else begin
      halt_s        = 1'b0;
      halt_status_s = ST_NONE;
    end
  end

  // Run sequencer: reset hold, counted run, register dump and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= S_IDLE;
      hold_cnt_r     <= {HW{1'b0}};
      core_rst_n_r   <= 1'b0;
      core_en_r      <= 1'b0;
      dump_valid_r   <= 1'b0;
      dump_idx_r     <= {IW{1'b0}};
      done_r         <= 1'b0;
      status_r       <= ST_NONE;
      cycle_count_r  <= {CW{1'b0}};
      tohost_value_r <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          core_en_r <= 1'b0;
          if (start) begin
            // A new run clears all results and puts the core back in reset.
            state_r        <= S_HOLD;
            hold_cnt_r     <= HOLD_LOAD;
            core_rst_n_r   <= 1'b0;
            done_r         <= 1'b0;
            status_r       <= ST_NONE;
            cycle_count_r  <= {CW{1'b0}};
            tohost_value_r <= {XLEN{1'b0}};
          end
        end
        S_HOLD: begin
          if (hold_cnt_r == {HW{1'b0}}) begin
            state_r      <= S_RUN;
            core_rst_n_r <= 1'b1;
            core_en_r    <= 1'b1;
          end else begin
            hold_cnt_r <= hold_cnt_r - HW'(1);
          end
        end
        S_RUN: begin
          cycle_count_r <= cycle_count_r + CW'(1);
          if (halt_s) begin
            // Freeze the core but keep it out of reset so the regfile survives.
            status_r  <= halt_status_s;
            core_en_r <= 1'b0;
            if (tohost_hit_s) begin
              tohost_value_r <= mem_wdata;
            end
            if (DUMP_EN) begin
              state_r      <= S_DUMP;
              dump_valid_r <= 1'b1;
              dump_idx_r   <= {IW{1'b0}};
            end else begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
            end
          end
        end
        S_DUMP: begin
          if (dump_valid_r && dump.dump_ready) begin
            if (dump_idx_r == LAST_IDX) begin
              state_r      <= S_DONE;
              dump_valid_r <= 1'b0;
              dump_idx_r   <= {IW{1'b0}};
              done_r       <= 1'b1;
            end else begin
              dump_idx_r <= dump_idx_r + IW'(1);
            end
          end
        end
        default: begin
          state_r      <= S_IDLE;
          core_rst_n_r <= 1'b0;
          core_en_r    <= 1'b0;
          dump_valid_r <= 1'b0;
          dump_idx_r   <= {IW{1'b0}};
          done_r       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/risky_run_ctrl.md
# risky_run_ctrl

Synthesizable run controller for the `risky` core. It sequences the core's reset release and counts executed cycles. It detects program completion (ECALL retirement, tohost store, or cycle-limit timeout), then freezes the core and streams the register file out over a valid/ready port. It sits between the top-level harness or FPGA wrapper and `risky`, and replaces fixed-length simulation runs and ad-hoc register printing.

## Interface
Parameters:
- `XLEN`, 32: register/data width.
- `NUM_REGS`, 32: registers dumped, indices 0..NUM_REGS-1.
- `RESET_CYCLES`, 2: cycles `core_rst_n` is held low after start; legal values are 1 or more.
- `MAX_CYCLES`, 100: run-cycle limit before timeout; legal values are 1 or more.
- `TOHOST_ADDR`, 32'h0000_1000: halt-on-store address.
- `DUMP_EN`, 1: if 0, skip the DUMP state.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a run; sampled only in IDLE or DONE.
- `core_rst_n` out 1: reset to core, active-low, registered.
- `core_en` out 1: core clock-enable/advance, registered.
- `retire_valid` in 1: core retired an instruction this cycle.
- `retire_is_ecall` in 1: retired instruction is ECALL/EBREAK; qualified by `retire_valid`.
- `mem_we`, `mem_addr[XLEN]`, `mem_wdata[XLEN]` in: core data-store snoop.
- `rf_raddr` out $clog2(NUM_REGS): debug read address to regfile.
- `rf_rdata` in XLEN: combinational regfile read data.
- `dump_valid` out 1, `dump_ready` in 1: dump handshake.
- `dump_idx` out $clog2(NUM_REGS), `dump_data` out XLEN: dump beat.
- `done` out 1: run finished and dump complete.
- `status` out 2: 0 none, 1 ecall, 2 tohost, 3 timeout.
- `cycle_count` out $clog2(MAX_CYCLES+1): cycles spent in RUN.
- `tohost_value` out XLEN: captured tohost store data.

## Operation
- Reset (async, `rst_n`=0) drives state IDLE and the following outputs:
  - `core_rst_n`=0, `core_en`=0.
  - `dump_valid`=0, `dump_idx`=0, `rf_raddr`=0.
  - `done`=0, `status`=0, `cycle_count`=0, `tohost_value`=0.
- Assertion of reset mid-run or mid-dump aborts immediately to the reset values.
- FSM states are IDLE, HOLD, RUN, DUMP, DONE.
- IDLE, with `start`=1: go to HOLD. Clear `cycle_count`, `status`, `tohost_value`; load the hold counter.
- HOLD: `core_rst_n`=0 and `core_en`=0 for exactly RESET_CYCLES cycles, then go to RUN.
- RUN: `core_rst_n`=1, `core_en`=1. `cycle_count` increments each RUN cycle. Halt conditions are evaluated every cycle:
  - tohost: `mem_we` && `mem_addr`==TOHOST_ADDR && `mem_wdata`!=0. Capture `mem_wdata` into `tohost_value`.
  - ecall: `retire_valid` && `retire_is_ecall`.
  - timeout: `cycle_count`==MAX_CYCLES-1 with no other event.
  - Priority when events coincide: tohost > ecall > timeout. Only the winner's status is recorded.
  - On halt: latch `status`, deassert `core_en` next cycle, and keep `core_rst_n`=1 so regfile contents are preserved. Go to DUMP (DUMP_EN=1) or DONE (DUMP_EN=0).
- DUMP: `dump_valid`=1, `rf_raddr`=`dump_idx`, `dump_data`=`rf_rdata`.
  - A beat transfers when `dump_valid` && `dump_ready`; `dump_idx` then increments.
  - While `dump_ready`=0, `dump_idx` and `dump_data` hold stable.
  - After the beat with `dump_idx`=NUM_REGS-1 transfers: `dump_valid`=0, `dump_idx`=0, go to DONE.
- DONE: `done`=1; `status`, `cycle_count`, `tohost_value` hold. `core_en`=0.
  - `start`=1 returns to HOLD and clears `done` and all counters and results.
- `start` is ignored in HOLD, RUN and DUMP.

## Timing
- All outputs are registered except `dump_data`, which is a combinational pass-through of `rf_rdata`.
- Clock edges relative to the `start` edge:
  - Edge E0, `start` sampled: state becomes HOLD.
  - Edge E0+RESET_CYCLES: state becomes RUN and `core_rst_n` rises.
  - Event sampled at edge Eh: `core_en`=0 and `status` valid after Eh; `dump_valid`=1 after Eh.
- With `dump_ready` tied high, a dump takes NUM_REGS cycles. `done` rises on the edge after the last beat.
- Timeout with no events: RUN lasts exactly MAX_CYCLES cycles, and the final `cycle_count` equals MAX_CYCLES.
- `cycle_count` never wraps; it stops at the halt.

## Test plan
- Timeout: MAX_CYCLES=100, no events, `dump_ready`=1 -> `core_rst_n` low for 2 cycles after start. Then `status`=3, `cycle_count`=100, 32 beats with idx 0..31, `done`=1.
- ECALL halt: `retire_valid`=`retire_is_ecall`=1 at RUN cycle 10 -> `status`=1, `cycle_count`=11, `core_en`=0 the next cycle, dump follows.
- Tohost vs ecall coincident: store of 32'h1 to 32'h1000 and ECALL in the same cycle -> `status`=2, `tohost_value`=1. A store of 0 to TOHOST_ADDR does not halt.
- Backpressure: toggle `dump_ready` pseudo-randomly with the regfile preloaded x[i]=i*4 -> every beat satisfies `dump_data`=`dump_idx`*4, idx/data stable while stalled, no index skipped or repeated.
- Restart and ignore: `start` pulsed during RUN -> no effect. `start` in DONE -> `done`=0, `cycle_count`=0, a new run proceeds normally.
- Reset mid-dump: `rst_n`=0 at beat 5 -> all outputs at reset values immediately, state IDLE, and a new `start` works.
